// File: rtl/tmnt_rom_pkg.sv
// Shared types and default SDRAM byte bases for the ROM arbiter.
// Requester indices double as bit positions in the pending/grant vectors.
package tmnt_rom_pkg;

    typedef enum logic [1:0] {
        REQ_M68K  = 2'd0,
        REQ_SPR   = 2'd1,
        REQ_TILES = 2'd2,
        REQ_THEME = 2'd3
    } req_idx_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic [25:0] DEF_M68K_BASE  = 26'h0000000;
    localparam logic [25:0] DEF_TILES_BASE = 26'h0100000;
    localparam logic [25:0] DEF_SPR_BASE   = 26'h0200000;
    localparam logic [25:0] DEF_THEME_BASE = 26'h0400000;

    // Rotation order among video requesters: sprites -> tiles -> theme -> sprites.
    function automatic req_idx_e next_video(input req_idx_e r);
        case (r)
            REQ_SPR:   return REQ_TILES;
            REQ_TILES: return REQ_THEME;
            default:   return REQ_SPR;
        endcase
    endfunction

    function automatic req_idx_e grant_idx(input logic [3:0] g);
        if (g[REQ_SPR])        return REQ_SPR;
        else if (g[REQ_TILES]) return REQ_TILES;
        else if (g[REQ_THEME]) return REQ_THEME;
        else                   return REQ_M68K;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester and SDRAM-controller signals of the ROM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface rom_arbiter_if;
    logic        load_en;
    logic        m68k_rom_req;
    logic [17:0] m68k_rom_addr;
    logic [15:0] m68k_rom_dout;
    logic        sdram_dtack;
    logic        tiles_rom_req;
    logic [17:0] tiles_rom_addr;
    logic        spr_rom_req;
    logic [18:0] spr_rom_addr;
    logic        theme_rom_req;
    logic [17:0] theme_rom_addr;
    logic [31:0] tiles_rom_dout;
    logic [31:0] spr_rom_dout;
    logic [31:0] theme_rom_dout;
    logic        sdr_req;
    logic [25:0] sdr_addr;
    logic        sdr_ack;
    logic [31:0] sdr_dout;
    logic        arb_err;

    modport slave (
        input  load_en, m68k_rom_req, m68k_rom_addr, tiles_rom_req, tiles_rom_addr,
               spr_rom_req, spr_rom_addr, theme_rom_req, theme_rom_addr, sdr_ack, sdr_dout,
        output m68k_rom_dout, sdram_dtack, tiles_rom_dout, spr_rom_dout, theme_rom_dout,
               sdr_req, sdr_addr, arb_err
    );

    modport master (
        output load_en, m68k_rom_req, m68k_rom_addr, tiles_rom_req, tiles_rom_addr,
               spr_rom_req, spr_rom_addr, theme_rom_req, theme_rom_addr, sdr_ack, sdr_dout,
        input  m68k_rom_dout, sdram_dtack, tiles_rom_dout, spr_rom_dout, theme_rom_dout,
               sdr_req, sdr_addr, arb_err
    );
endinterface

// File: rtl/rom_arb_prio.sv
// Winner selection: 68k always first, then video requesters starting at rr_ptr.
// With rr_ptr held at REQ_SPR this is the fixed order sprites > tiles > theme.
module rom_arb_prio
    import tmnt_rom_pkg::*;
(
    input  logic [3:0] pend,
    input  req_idx_e   rr_ptr,
    output logic [3:0] grant
);
    req_idx_e c0, c1, c2;

    assign c0 = rr_ptr;
    assign c1 = next_video(c0);
    assign c2 = next_video(c1);

    always_comb begin
        grant = '0;
        if (pend[REQ_M68K]) grant[REQ_M68K] = 1'b1;
        else if (pend[c0])  grant[c0]       = 1'b1;
        else if (pend[c1])  grant[c1]       = 1'b1;
        else if (pend[c2])  grant[c2]       = 1'b1;
    end
endmodule

// File: rtl/rom_arbiter.sv
// Four-requester ROM arbiter in front of a single SDRAM read port.
// Define ROM_ARB_RR_EN to rotate priority among the video requesters.
module rom_arbiter
    import tmnt_rom_pkg::*;
#(
    parameter logic [25:0] M68K_BASE  = DEF_M68K_BASE,
    parameter logic [25:0] TILES_BASE = DEF_TILES_BASE,
    parameter logic [25:0] SPR_BASE   = DEF_SPR_BASE,
    parameter logic [25:0] THEME_BASE = DEF_THEME_BASE,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic         clk_sys,
    input  logic         nRESET,
    rom_arbiter_if.slave bus
);
    logic [3:0]  strb, clr, pending_d, pending_q, eff_pend, grant;
    logic [17:0] m68k_addr_d, m68k_addr_q, tiles_addr_d, tiles_addr_q;
    logic [17:0] theme_addr_d, theme_addr_q;
    logic [18:0] spr_addr_d, spr_addr_q;
    logic [25:0] grant_addr, sdr_addr_q;
    logic [15:0] m68k_dout_q;
    logic [31:0] tiles_dout_q, spr_dout_q, theme_dout_q;
    logic [7:0]  timer_q;
    logic        sdr_req_q, dtack_q, err_q, timeout;
    req_idx_e    grant_ix, winner_q, rr_ptr;
    arb_state_e  state_q;

    // Strobes are dropped entirely while the HPS owns the SDRAM.
    assign strb = {bus.theme_rom_req, bus.tiles_rom_req, bus.spr_rom_req, bus.m68k_rom_req}
                  & {4{~bus.load_en}};
    assign eff_pend = pending_q | strb;
    assign grant_ix = grant_idx(grant);
    assign timeout  = (state_q == WAIT) && !bus.sdr_ack && (timer_q == TIMEOUT - 8'd1);

`ifdef ROM_ARB_RR_EN
    req_idx_e rr_ptr_q;
    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = REQ_SPR;
`endif

    rom_arb_prio u_prio (
        .pend   (eff_pend),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    always_comb begin
        m68k_addr_d  = strb[REQ_M68K]  ? bus.m68k_rom_addr  : m68k_addr_q;
        spr_addr_d   = strb[REQ_SPR]   ? bus.spr_rom_addr   : spr_addr_q;
        tiles_addr_d = strb[REQ_TILES] ? bus.tiles_rom_addr : tiles_addr_q;
        theme_addr_d = strb[REQ_THEME] ? bus.theme_rom_addr : theme_addr_q;
        clr = '0;
        if (state_q == ISSUE) clr[winner_q] = 1'b1;
        // A strobe landing on the clearing edge re-arms the requester.
        pending_d = bus.load_en ? 4'b0 : ((pending_q & ~clr) | strb);
        case (grant_ix)
            REQ_M68K:  grant_addr = M68K_BASE  + {7'b0, m68k_addr_d, 1'b0};
            REQ_SPR:   grant_addr = SPR_BASE   + {5'b0, spr_addr_d, 2'b00};
            REQ_TILES: grant_addr = TILES_BASE + {6'b0, tiles_addr_d, 2'b00};
            default:   grant_addr = THEME_BASE + {6'b0, theme_addr_d, 2'b00};
        endcase
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            pending_q    <= '0;
            m68k_addr_q  <= '0;
            spr_addr_q   <= '0;
            tiles_addr_q <= '0;
            theme_addr_q <= '0;
        end else begin
            pending_q    <= pending_d;
            m68k_addr_q  <= m68k_addr_d;
            spr_addr_q   <= spr_addr_d;
            tiles_addr_q <= tiles_addr_d;
            theme_addr_q <= theme_addr_d;
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= IDLE;
            winner_q     <= REQ_M68K;
            sdr_req_q    <= 1'b0;
            sdr_addr_q   <= '0;
            timer_q      <= '0;
            m68k_dout_q  <= '0;
            spr_dout_q   <= '0;
            tiles_dout_q <= '0;
            theme_dout_q <= '0;
            dtack_q      <= 1'b1;
            err_q        <= 1'b0;
`ifdef ROM_ARB_RR_EN
            rr_ptr_q     <= REQ_SPR;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    sdr_req_q <= 1'b0;
                    if (!bus.load_en && |eff_pend) begin
                        winner_q   <= grant_ix;
                        sdr_addr_q <= grant_addr;
                        sdr_req_q  <= 1'b1;
                        state_q    <= ISSUE;
`ifdef ROM_ARB_RR_EN
                        if (grant_ix != REQ_M68K) rr_ptr_q <= next_video(grant_ix);
`endif
                    end
                end
                ISSUE: begin
                    sdr_req_q <= 1'b0;
                    timer_q   <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (bus.sdr_ack) begin
                        state_q <= IDLE;
                        if (!bus.load_en) begin
                            case (winner_q)
                                REQ_M68K:  m68k_dout_q  <= bus.sdr_dout[15:0];
                                REQ_SPR:   spr_dout_q   <= bus.sdr_dout;
                                REQ_TILES: tiles_dout_q <= bus.sdr_dout;
                                default:   theme_dout_q <= bus.sdr_dout;
                            endcase
                        end
                    end else if (timeout) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (bus.load_en)
                dtack_q <= 1'b1;
            else if (strb[REQ_M68K])
                dtack_q <= 1'b0;
            else if (state_q == WAIT && winner_q == REQ_M68K && (bus.sdr_ack || timeout))
                dtack_q <= 1'b1;
        end
    end

    assign bus.sdr_req        = sdr_req_q;
    assign bus.sdr_addr       = sdr_addr_q;
    assign bus.m68k_rom_dout  = m68k_dout_q;
    assign bus.spr_rom_dout   = spr_dout_q;
    assign bus.tiles_rom_dout = tiles_dout_q;
    assign bus.theme_rom_dout = theme_dout_q;
    assign bus.sdram_dtack    = dtack_q | bus.load_en;
    assign bus.arb_err        = err_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with hand-computed expected values.
module tb_rom_arbiter;
    logic clk_sys = 1'b0;
    logic nRESET  = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   req_pulses = 0;
    int   p0;

    rom_arbiter_if bus ();

    rom_arbiter dut (
        .clk_sys (clk_sys),
        .nRESET  (nRESET),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (bus.sdr_req === 1'b1) req_pulses++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Wait (bounded) for the issue pulse, check its address, then ack one cycle later.
    task automatic issue_and_ack(input string tag, input logic [25:0] exp_addr,
                                 input logic [31:0] data);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (bus.sdr_req === 1'b1) seen = 1'b1;
            else tick();
        end
        check_val({tag, "_req"}, 32'(seen), 32'd1);
        if (seen) begin
            check_val({tag, "_addr"}, 32'(bus.sdr_addr), 32'(exp_addr));
            tick();
            bus.sdr_ack  = 1'b1;
            bus.sdr_dout = data;
            tick();
            bus.sdr_ack  = 1'b0;
        end
    endtask

    initial begin
        bus.load_en = 0;
        bus.m68k_rom_req = 0;  bus.m68k_rom_addr = '0;
        bus.spr_rom_req = 0;   bus.spr_rom_addr = '0;
        bus.tiles_rom_req = 0; bus.tiles_rom_addr = '0;
        bus.theme_rom_req = 0; bus.theme_rom_addr = '0;
        bus.sdr_ack = 0;       bus.sdr_dout = '0;

        // Reset values
        repeat (3) tick();
        check_val("rst_req",   32'(bus.sdr_req), 32'd0);
        check_val("rst_addr",  32'(bus.sdr_addr), 32'd0);
        check_val("rst_m68k",  32'(bus.m68k_rom_dout), 32'd0);
        check_val("rst_spr",   bus.spr_rom_dout, 32'd0);
        check_val("rst_dtack", 32'(bus.sdram_dtack), 32'd1);
        check_val("rst_err",   32'(bus.arb_err), 32'd0);
        nRESET = 1'b1;
        tick();

        // Single 68k read
        bus.m68k_rom_addr = 18'h00010; bus.m68k_rom_req = 1;
        tick();
        bus.m68k_rom_req = 0;
        check_val("m68k_req",   32'(bus.sdr_req), 32'd1);
        check_val("m68k_addr",  32'(bus.sdr_addr), 32'h20);
        check_val("m68k_dtack_lo", 32'(bus.sdram_dtack), 32'd0);
        tick();
        check_val("m68k_req_one", 32'(bus.sdr_req), 32'd0);
        bus.sdr_ack = 1; bus.sdr_dout = 32'hAAAA1234;
        tick();
        bus.sdr_ack = 0;
        check_val("m68k_dout",  32'(bus.m68k_rom_dout), 32'h1234);
        check_val("m68k_dtack_hi", 32'(bus.sdram_dtack), 32'd1);
        check_val("tiles_untouched", bus.tiles_rom_dout, 32'd0);

        // Stray ack in IDLE
        bus.sdr_ack = 1; bus.sdr_dout = 32'hFFFF5555;
        tick();
        bus.sdr_ack = 0;
        check_val("idle_ack_dout", 32'(bus.m68k_rom_dout), 32'h1234);
        check_val("idle_ack_req",  32'(bus.sdr_req), 32'd0);

        // Three requesters on one edge, tiles re-strobed while 68k in flight
        p0 = req_pulses;
        bus.m68k_rom_addr = 18'h7;  bus.m68k_rom_req = 1;
        bus.spr_rom_addr = 19'h5;   bus.spr_rom_req = 1;
        bus.tiles_rom_addr = 18'h3; bus.tiles_rom_req = 1;
        tick();
        bus.m68k_rom_req = 0; bus.spr_rom_req = 0;
        check_val("tri_m68k_req",  32'(bus.sdr_req), 32'd1);
        check_val("tri_m68k_addr", 32'(bus.sdr_addr), 32'hE);
        bus.tiles_rom_addr = 18'h9;
        tick();
        bus.tiles_rom_req = 0;
        bus.sdr_ack = 1; bus.sdr_dout = 32'h11112222;
        tick();
        bus.sdr_ack = 0;
        check_val("tri_m68k_dout", 32'(bus.m68k_rom_dout), 32'h2222);
        issue_and_ack("tri_spr", 26'h0200014, 32'h33334444);
        check_val("tri_spr_dout", bus.spr_rom_dout, 32'h33334444);
        issue_and_ack("tri_tiles", 26'h0100024, 32'h55556666);
        check_val("tri_tiles_dout", bus.tiles_rom_dout, 32'h55556666);
        repeat (3) tick();
        check_val("tri_pulses", 32'(req_pulses - p0), 32'd3);

        // Timeout on a 68k read
        bus.m68k_rom_addr = 18'h2; bus.m68k_rom_req = 1;
        tick();
        bus.m68k_rom_req = 0;
        check_val("to_addr", 32'(bus.sdr_addr), 32'h4);
        repeat (255) tick();
        check_val("to_err_early",   32'(bus.arb_err), 32'd0);
        check_val("to_dtack_early", 32'(bus.sdram_dtack), 32'd0);
        tick();
        check_val("to_err",   32'(bus.arb_err), 32'd1);
        check_val("to_dtack", 32'(bus.sdram_dtack), 32'd1);
        check_val("to_dout",  32'(bus.m68k_rom_dout), 32'h2222);
        bus.spr_rom_addr = 19'h0; bus.spr_rom_req = 1;
        tick();
        bus.spr_rom_req = 0;
        issue_and_ack("to_idle_spr", 26'h0200000, 32'h77778888);
        check_val("to_idle_spr_dout", bus.spr_rom_dout, 32'h77778888);

        // load_en rises while tiles read is in WAIT with theme pending
        bus.tiles_rom_addr = 18'h4; bus.tiles_rom_req = 1;
        tick();
        bus.tiles_rom_req = 0;
        check_val("ld_tiles_addr", 32'(bus.sdr_addr), 32'h0100010);
        tick();
        bus.theme_rom_addr = 18'h6; bus.theme_rom_req = 1;
        tick();
        bus.theme_rom_req = 0;
        bus.load_en = 1;
        p0 = req_pulses;
        tick();
        bus.sdr_ack = 1; bus.sdr_dout = 32'hDEADBEEF;
        tick();
        bus.sdr_ack = 0;
        bus.m68k_rom_req = 1;
        tick();
        bus.m68k_rom_req = 0;
        check_val("ld_dtack", 32'(bus.sdram_dtack), 32'd1);
        repeat (4) tick();
        bus.load_en = 0;
        repeat (5) tick();
        check_val("ld_tiles_dout", bus.tiles_rom_dout, 32'h55556666);
        check_val("ld_theme_dout", bus.theme_rom_dout, 32'd0);
        check_val("ld_pulses", 32'(req_pulses - p0), 32'd0);

        // Reset in WAIT, late ack ignored
        bus.spr_rom_addr = 19'h8; bus.spr_rom_req = 1;
        tick();
        bus.spr_rom_req = 0;
        tick();
        nRESET = 1'b0;
        #1;
        check_val("wr_req",   32'(bus.sdr_req), 32'd0);
        check_val("wr_addr",  32'(bus.sdr_addr), 32'd0);
        check_val("wr_m68k",  32'(bus.m68k_rom_dout), 32'd0);
        check_val("wr_spr",   bus.spr_rom_dout, 32'd0);
        check_val("wr_tiles", bus.tiles_rom_dout, 32'd0);
        check_val("wr_dtack", 32'(bus.sdram_dtack), 32'd1);
        check_val("wr_err",   32'(bus.arb_err), 32'd0);
        tick();
        nRESET = 1'b1;
        p0 = req_pulses;
        bus.sdr_ack = 1; bus.sdr_dout = 32'h99999999;
        tick();
        bus.sdr_ack = 0;
        repeat (3) tick();
        check_val("wr_late_ack", bus.spr_rom_dout, 32'd0);
        check_val("wr_pulses", 32'(req_pulses - p0), 32'd0);

        // Sprites re-strobed while in flight, tiles waiting
        bus.spr_rom_addr = 19'h1;   bus.spr_rom_req = 1;
        bus.tiles_rom_addr = 18'h1; bus.tiles_rom_req = 1;
        tick();
        bus.tiles_rom_req = 0;
        check_val("rr_first_addr", 32'(bus.sdr_addr), 32'h0200004);
        bus.spr_rom_addr = 19'h2;
        tick();
        bus.spr_rom_req = 0;
        bus.sdr_ack = 1; bus.sdr_dout = 32'h0A0A0A0A;
        tick();
        bus.sdr_ack = 0;
`ifdef ROM_ARB_RR_EN
        issue_and_ack("rr_second", 26'h0100004, 32'h0B0B0B0B);
        issue_and_ack("rr_third",  26'h0200008, 32'h0C0C0C0C);
        check_val("rr_spr_dout",   bus.spr_rom_dout,   32'h0C0C0C0C);
        check_val("rr_tiles_dout", bus.tiles_rom_dout, 32'h0B0B0B0B);
`else
        issue_and_ack("fx_second", 26'h0200008, 32'h0B0B0B0B);
        issue_and_ack("fx_third",  26'h0100004, 32'h0C0C0C0C);
        check_val("fx_spr_dout",   bus.spr_rom_dout,   32'h0B0B0B0B);
        check_val("fx_tiles_dout", bus.tiles_rom_dout, 32'h0C0C0C0C);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter M68K_BASE, default 26'h0000000, SDRAM byte base of 68k program ROM.
REQ-002 SHALL have parameter TILES_BASE, default 26'h0100000, SDRAM byte base of tile ROM.
REQ-003 SHALL have parameter SPR_BASE, default 26'h0200000, SDRAM byte base of sprite ROM.
REQ-004 SHALL have parameter THEME_BASE, default 26'h0400000, SDRAM byte base of theme ROM.
REQ-005 SHALL have parameter TIMEOUT, default 8'd255, max WAIT cycles before abort.
REQ-006 Ports, in order:
- clk_sys  in  1  96 MHz system clock, all logic on rising edge.
- nRESET  in  1  asynchronous active-low reset.
- load_en  in  1  HPS ROM download active; SDRAM not owned by arbiter.
- m68k_rom_req / m68k_rom_addr  in  1/18  one-cycle strobe; 16-bit word address.
- m68k_rom_dout  out  16  68k read data.
- sdram_dtack  out  1  high = 68k data valid / no stall.
- tiles_rom_req / tiles_rom_addr  in  1/18  one-cycle strobe; 32-bit word address.
- spr_rom_req / spr_rom_addr  in  1/19  as above.
- theme_rom_req / theme_rom_addr  in  1/18  as above.
- tiles_rom_dout, spr_rom_dout, theme_rom_dout  out  32  per-requester held data.
- sdr_req  out  1  one-cycle command strobe to SDRAM controller.
- sdr_addr  out  26  byte address.
- sdr_ack  in  1  one-cycle data-valid strobe.
- sdr_dout  in  32  SDRAM read data.
- arb_err  out  1  sticky timeout flag.

Function
REQ-007 SHALL keep one pending bit + latched address per requester; strobe sets the bit and overwrites the address in the same edge.
REQ-008 A strobe for a requester already pending SHALL overwrite its address (latest wins); a strobe for the requester in service SHALL set pending anew.
REQ-009 FSM states SHALL be IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when any pending and load_en=0; winner latched.
- ISSUE: sdr_req=1 for exactly one cycle; winner's pending bit cleared; -> WAIT.
- WAIT -> IDLE on sdr_ack, or on TIMEOUT cycles elapsed.
REQ-010 Strobe sampled on edge N in IDLE with nothing pending SHALL give sdr_req=1 during cycle N+1.
REQ-011 sdr_addr SHALL be M68K_BASE+{addr,1'b0} for 68k, else BASE+{addr,2'b00}; sum truncated to 26 bits.
REQ-012 On sdr_ack, winner's dout SHALL load on that edge (68k: sdr_dout[15:0]); other douts unchanged.
REQ-013 sdram_dtack SHALL drop on the edge sampling m68k_rom_req and rise on the edge loading m68k_rom_dout.
REQ-014 Timeout SHALL set arb_err, leave dout unchanged, and raise sdram_dtack if 68k was served; cleared only by reset.
REQ-015 While load_en=1: no new grants, all pending cleared, strobes ignored, sdram_dtack=1; transaction in WAIT completes or times out, data discarded.
REQ-016 sdr_ack outside WAIT SHALL be ignored.

Reset
REQ-017 nRESET low SHALL force IDLE, all pending=0, sdr_req=0, sdr_addr=0, all douts=0, sdram_dtack=1, arb_err=0, RR pointer=sprites; abort any transaction immediately.

Configuration
REQ-018 Without ROM_ARB_RR_EN: fixed priority 68k > sprites > tiles > theme.
REQ-019 With ROM_ARB_RR_EN: 68k remains highest; sprites/tiles/theme rotate, last-served video requester becomes lowest.

Structure
REQ-020 Package tmnt_rom_pkg SHALL hold requester index enum (REQ_M68K, REQ_SPR, REQ_TILES, REQ_THEME), FSM state enum and default base constants.
REQ-021 Winner selection SHALL be sub-module rom_arb_prio (pending vector + RR pointer in, one-hot grant out).

Verification
REQ-022 Single 68k strobe addr 18'h00010, M68K_BASE=0 -> sdr_req next cycle, sdr_addr=26'h20; ack with 32'hAAAA1234 -> m68k_rom_dout=16'h1234, sdram_dtack high on same edge.
REQ-023 Tiles, sprites, 68k strobes same edge -> grant order 68k, sprites, tiles (fixed); three sdr_req pulses.
REQ-024 ROM_ARB_RR_EN, sprites and tiles strobing every 32 cycles, ack latency 20 -> grants alternate; no requester served twice consecutively while other pending.
REQ-025 No sdr_ack after grant -> return to IDLE after 255 WAIT cycles, arb_err=1, sdram_dtack=1.
REQ-026 load_en rises mid-WAIT with theme pending -> current ack discarded, theme pending cleared, no sdr_req until load_en falls.
REQ-027 nRESET asserted in WAIT -> sdr_req=0, all outputs at reset values same cycle; later ack ignored.
